// File: rtl/calc_bcd_converter_pkg.sv
// Shared types and constants for the calculator BCD converter stage.
// Holds the converter FSM encoding and the digit-count sanity function.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } calc_bcd_state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_BLANK   = 4'hF;

  // True when DIGITS decimal digits can represent every WIDTH-bit magnitude.
  function automatic bit bcd_digits_fit(input int width, input int digits);
    longint unsigned pow10;
    longint unsigned maxVal;
    pow10 = 64'd1;
    for (int i = 0; i < digits; i++) begin
      pow10 = pow10 * 64'd10;
    end
    maxVal = (64'd1 << width) - 64'd1;
    return (pow10 > maxVal);
  endfunction

endpackage

// File: rtl/calc_bcd_converter_add3.sv
// Single-digit double-dabble adjust: digits of 5 or more get +3 before the shift.
module bcd_add3
  import calc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/calc_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble) with a start/valid handshake.
// Define CALC_BCD_LZ_BLANK_EN to replace leading-zero digits with the blank code.
module calc_bcd_converter
  import calc_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          sign_in,
  input  logic [WIDTH-1:0]              mag_in,
  output logic                          busy,
  output logic                          valid,
  output logic                          sign_out,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int SW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (!bcd_digits_fit(WIDTH, DIGITS)) begin : g_param_check
      $error("calc_bcd_converter: DIGITS too small for WIDTH");
    end
  endgenerate

  calc_bcd_state_t r_state;
  logic [WIDTH-1:0] r_bin;
  logic [SW-1:0]    r_scratch;
  logic [CW-1:0]    r_count;
  logic             r_sign;
  logic             r_zero;
  logic [SW-1:0]    r_bcd;
  logic             r_sign_out;

  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_next_scratch;
  logic [WIDTH-1:0] w_next_bin;
  logic [SW-1:0]    w_final;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_add3 u_add3 (
        .i_digit(r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_digit(w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  assign w_next_scratch = {w_adj[SW-2:0], r_bin[WIDTH-1]};
  assign w_next_bin     = {r_bin[WIDTH-2:0], 1'b0};

  // The shift that reaches DONE loads the outputs directly from the next-scratch value.
`ifdef CALC_BCD_LZ_BLANK_EN
  logic w_lead_zero;
  always_comb begin
    w_final     = w_next_scratch;
    w_lead_zero = 1'b1;
    for (int d = DIGITS - 1; d > 0; d--) begin
      if (w_lead_zero && (w_next_scratch[d*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0)) begin
        w_final[d*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
      end else begin
        w_lead_zero = 1'b0;
      end
    end
  end
`else
  always_comb begin
    w_final = w_next_scratch;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_scratch  <= '0;
      r_count    <= '0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_bcd      <= '0;
      r_sign_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_bin     <= mag_in;
            r_scratch <= '0;
            r_sign    <= sign_in;
            r_zero    <= (mag_in == '0);
            r_count   <= CW'(WIDTH);
            r_state   <= SHIFT;
          end else begin
            r_state   <= IDLE;
          end
        end
        SHIFT: begin
          r_scratch <= w_next_scratch;
          r_bin     <= w_next_bin;
          r_count   <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_state    <= DONE;
            r_bcd      <= w_final;
            r_sign_out <= r_sign & ~r_zero;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state == SHIFT);
  assign valid    = (r_state == DONE);
  assign sign_out = r_sign_out;
  assign bcd_out  = r_bcd;

endmodule

// File: tb/tb_calc_bcd_converter.sv
// Directed self-checking bench for calc_bcd_converter (raw or leading-zero-blank build).
module tb_calc_bcd_converter;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sign_in;
  logic [8:0]  mag_in;
  logic        busy;
  logic        valid;
  logic        sign_out;
  logic [11:0] bcd_out;

  int checks = 0;
  int errors = 0;

  calc_bcd_converter #(.WIDTH(9), .DIGITS(3)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .sign_in(sign_in),
    .mag_in(mag_in),
    .busy(busy),
    .valid(valid),
    .sign_out(sign_out),
    .bcd_out(bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written raw BCD, blanked the way the blank build presents it.
  function automatic logic [11:0] expBcd(input logic [11:0] raw);
    logic [11:0] r;
    r = raw;
`ifdef CALC_BCD_LZ_BLANK_EN
    if (r[11:8] == 4'd0) begin
      r[11:8] = 4'hF;
      if (r[7:4] == 4'd0) r[7:4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic startPulse(input logic [8:0] mag, input logic sgn);
    @(negedge clk);
    start   = 1'b1;
    mag_in  = mag;
    sign_in = sgn;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mag_in  = 9'h1AA;
    sign_in = ~sgn;
  endtask

  task automatic waitValid(output int cycles, output int busyCount);
    cycles    = -1;
    busyCount = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busyCount++;
      if (valid) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    sign_in = 1'b0;
    mag_in = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
    checks++; if (sign_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_sign got %b want 0", sign_out); end
    checks++; if (bcd_out !== 12'h000) begin errors++; $display("[TB] FAIL reset_bcd got %h want 000", bcd_out); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int cyc, bcnt;
    startPulse(9'd255, 1'b0);
    waitValid(cyc, bcnt);
    checks++; if (cyc !== 10) begin errors++; $display("[TB] FAIL basic_latency got %0d want 10", cyc); end
    checks++; if (bcnt !== 9) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want 9", bcnt); end
    checks++; if (bcd_out !== 12'h255) begin errors++; $display("[TB] FAIL basic_bcd got %h want 255", bcd_out); end
    checks++; if (sign_out !== 1'b0) begin errors++; $display("[TB] FAIL basic_sign got %b want 0", sign_out); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_pulse got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    checks++; if (bcd_out !== 12'h255) begin errors++; $display("[TB] FAIL basic_hold got %h want 255", bcd_out); end
  endtask

  task automatic test_sign;
    int cyc, bcnt;
    startPulse(9'd511, 1'b1);
    waitValid(cyc, bcnt);
    checks++; if (cyc !== 10) begin errors++; $display("[TB] FAIL max_latency got %0d want 10", cyc); end
    checks++; if (bcd_out !== 12'h511) begin errors++; $display("[TB] FAIL max_bcd got %h want 511", bcd_out); end
    checks++; if (sign_out !== 1'b1) begin errors++; $display("[TB] FAIL max_sign got %b want 1", sign_out); end
    startPulse(9'd0, 1'b1);
    waitValid(cyc, bcnt);
    checks++; if (bcd_out !== expBcd(12'h000)) begin errors++; $display("[TB] FAIL zero_bcd got %h want %h", bcd_out, expBcd(12'h000)); end
    checks++; if (sign_out !== 1'b0) begin errors++; $display("[TB] FAIL neg_zero_sign got %b want 0", sign_out); end
  endtask

  task automatic test_ignore_start;
    int cyc, bcnt, extraValid;
    startPulse(9'd100, 1'b0);
    repeat (3) @(negedge clk);
    startPulse(9'd7, 1'b1);
    waitValid(cyc, bcnt);
    checks++; if (cyc !== 6) begin errors++; $display("[TB] FAIL ignore_latency got %0d want 6", cyc); end
    checks++; if (bcd_out !== 12'h100) begin errors++; $display("[TB] FAIL ignore_bcd got %h want 100", bcd_out); end
    extraValid = 0;
    repeat (20) begin
      @(negedge clk);
      if (valid || busy) extraValid++;
    end
    checks++; if (extraValid !== 0) begin errors++; $display("[TB] FAIL ignore_second_result got %0d want 0", extraValid); end
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt;
    startPulse(9'd300, 1'b0);
    waitValid(cyc, bcnt);
    checks++; if (bcd_out !== 12'h300) begin errors++; $display("[TB] FAIL b2b_first got %h want 300", bcd_out); end
    start  = 1'b1;
    mag_in = 9'd42;
    sign_in = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mag_in = 9'd0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy got %b want 1", busy); end
    checks++; if (bcd_out !== 12'h300) begin errors++; $display("[TB] FAIL b2b_hold got %h want 300", bcd_out); end
    waitValid(cyc, bcnt);
    checks++; if (cyc !== 9) begin errors++; $display("[TB] FAIL b2b_spacing got %0d want 9", cyc); end
    checks++; if (bcd_out !== expBcd(12'h042)) begin errors++; $display("[TB] FAIL b2b_bcd got %h want %h", bcd_out, expBcd(12'h042)); end
    checks++; if (sign_out !== 1'b1) begin errors++; $display("[TB] FAIL b2b_sign got %b want 1", sign_out); end
  endtask

  task automatic test_reset_mid;
    int cyc, bcnt, seenValid;
    startPulse(9'd300, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got %b want 0", valid); end
    checks++; if (bcd_out !== 12'h000) begin errors++; $display("[TB] FAIL rst_mid_bcd got %h want 000", bcd_out); end
    checks++; if (sign_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_sign got %b want 0", sign_out); end
    @(negedge clk);
    reset = 1'b0;
    seenValid = 0;
    repeat (15) begin
      @(negedge clk);
      if (valid) seenValid++;
    end
    checks++; if (seenValid !== 0) begin errors++; $display("[TB] FAIL rst_mid_no_valid got %0d want 0", seenValid); end
    startPulse(9'd99, 1'b0);
    waitValid(cyc, bcnt);
    checks++; if (cyc !== 10) begin errors++; $display("[TB] FAIL rst_mid_latency got %0d want 10", cyc); end
    checks++; if (bcd_out !== expBcd(12'h099)) begin errors++; $display("[TB] FAIL rst_mid_bcd99 got %h want %h", bcd_out, expBcd(12'h099)); end
  endtask

`ifdef CALC_BCD_LZ_BLANK_EN
  task automatic test_blank;
    int cyc, bcnt;
    startPulse(9'd7, 1'b0);
    waitValid(cyc, bcnt);
    checks++; if (bcd_out !== 12'hFF7) begin errors++; $display("[TB] FAIL blank_7 got %h want FF7", bcd_out); end
    startPulse(9'd0, 1'b0);
    waitValid(cyc, bcnt);
    checks++; if (bcd_out !== 12'hFF0) begin errors++; $display("[TB] FAIL blank_0 got %h want FF0", bcd_out); end
    startPulse(9'd105, 1'b0);
    waitValid(cyc, bcnt);
    checks++; if (bcd_out !== 12'h105) begin errors++; $display("[TB] FAIL blank_105 got %h want 105", bcd_out); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_sign;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
`ifdef CALC_BCD_LZ_BLANK_EN
    test_blank;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
